// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: conditions the buttons, lights one hole per round,
// times the lit window and keeps score/miss counts for the display.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for start after reset, lamps dark
// GAP    | dark pause between rounds, hole presses ignored
// UP     | one lamp lit, judging hit / wrong whack / timeout
// OVER   | miss limit reached, all lamps lit, counts held
module mole_round_scheduler #(
    parameter int unsigned NUM_HOLES  = 4,
    parameter int unsigned GAP_CYCLES = 50000000,
    parameter int unsigned UP_CYCLES  = 250000000,
    parameter int unsigned UP_STEP    = 25000000,
    parameter int unsigned UP_MIN     = 50000000,
    parameter int unsigned MAX_MISS   = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_n,
    input  logic [NUM_HOLES-1:0] btn_n,
    output logic [NUM_HOLES-1:0] lamp,
    output logic [31:0]          score,
    output logic [31:0]          miss,
    output logic                 ingame,
    output logic                 hit_pulse,
    output logic                 miss_pulse
);
    localparam int HB = $clog2(NUM_HOLES);
    localparam int NB = NUM_HOLES + 1;
    localparam logic [NUM_HOLES-1:0] HOLE_ONE = {{(NUM_HOLES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_OVER} state_t;

    state_t                 state_q, state_d;
    logic [NB-1:0]          sync1_q, sync2_q, hist_q;
    logic [15:0]            lfsr_q;
    logic [31:0]            up_len_q, up_len_d;
    logic [31:0]            timer_q, timer_d;
    logic [31:0]            score_q, score_d;
    logic [31:0]            miss_q, miss_d;
    logic [HB-1:0]          hole_q, hole_d;
    logic [NUM_HOLES-1:0]   lamp_q, lamp_d;
    logic                   ingame_q, ingame_d;
    logic                   hit_q, hit_d;
    logic                   missp_q, missp_d;

    logic [NB-1:0]          press;
    logic [NUM_HOLES-1:0]   btn_press, hole_mask;
    logic                   start_press;
    logic [HB-1:0]          cand;

    // Falling edge of the synchronised level; bounces deliberately count as presses.
    assign press       = hist_q & ~sync2_q;
    assign btn_press   = press[NUM_HOLES-1:0];
    assign start_press = press[NUM_HOLES];
    assign hole_mask   = HOLE_ONE << hole_q;
    assign cand        = lfsr_q[HB-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sync1_q  <= '1;
            sync2_q  <= '1;
            hist_q   <= '1;
            lfsr_q   <= LFSR_SEED;
            up_len_q <= UP_CYCLES;
            timer_q  <= '0;
            score_q  <= '0;
            miss_q   <= '0;
            hole_q   <= '0;
            lamp_q   <= '0;
            ingame_q <= 1'b0;
            hit_q    <= 1'b0;
            missp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= {start_n, btn_n};
            sync2_q  <= sync1_q;
            hist_q   <= sync2_q;
            lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            up_len_q <= up_len_d;
            timer_q  <= timer_d;
            score_q  <= score_d;
            miss_q   <= miss_d;
            hole_q   <= hole_d;
            lamp_q   <= lamp_d;
            ingame_q <= ingame_d;
            hit_q    <= hit_d;
            missp_q  <= missp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        up_len_d = up_len_q;
        timer_d  = timer_q;
        score_d  = score_q;
        miss_d   = miss_q;
        hole_d   = hole_q;
        hit_d    = 1'b0;
        missp_d  = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_press) begin
                    state_d  = S_GAP;
                    score_d  = '0;
                    miss_d   = '0;
                    up_len_d = UP_CYCLES;
                    timer_d  = '0;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_CYCLES - 1) begin
                    state_d = S_UP;
                    timer_d = '0;
                    hole_d  = (cand == hole_q) ? cand + HB'(1) : cand;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_UP: begin
                // Priority: hit, then timeout, then wrong whack.
                if (|(btn_press & hole_mask)) begin
                    score_d = score_q + 32'd1;
                    hit_d   = 1'b1;
                    state_d = S_GAP;
                    timer_d = '0;
                    if (score_d[2:0] == 3'd0) begin
                        up_len_d = (up_len_q >= UP_MIN + UP_STEP) ? up_len_q - UP_STEP : UP_MIN;
                    end
                end else if (timer_q == up_len_q - 32'd1) begin
                    miss_d  = miss_q + 32'd1;
                    missp_d = 1'b1;
                    timer_d = '0;
                    state_d = (miss_d == MAX_MISS) ? S_OVER : S_GAP;
                end else begin
                    timer_d = timer_q + 32'd1;
                    if (|(btn_press & ~hole_mask)) begin
                        miss_d  = miss_q + 32'd1;
                        missp_d = 1'b1;
                        if (miss_d == MAX_MISS) state_d = S_OVER;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lamp_d   = '0;
        ingame_d = 1'b0;
        case (state_d)
            S_GAP:   ingame_d = 1'b1;
            S_UP:    begin
                lamp_d   = HOLE_ONE << hole_d;
                ingame_d = 1'b1;
            end
            S_OVER:  lamp_d = '1;
            default: lamp_d = '0;
        endcase
    end

    assign lamp       = lamp_q;
    assign score      = score_q;
    assign miss       = miss_q;
    assign ingame     = ingame_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = missp_q;
endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for mole_round_scheduler with short game timings; expected values
// are hand-derived from the small parameter set below.
module tb_mole_round_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_n;
    logic [3:0]  btn_n;
    logic [3:0]  lamp;
    logic [31:0] score, miss;
    logic        ingame, hit_pulse, miss_pulse;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [3:0]  last_lamp;
    logic [3:0]  rec [0:2];
    logic [3:0]  h, other, w1, w2;
    int          n;

    mole_round_scheduler #(
        .NUM_HOLES(4), .GAP_CYCLES(5), .UP_CYCLES(20), .UP_STEP(4),
        .UP_MIN(8), .MAX_MISS(3), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start_n(start_n), .btn_n(btn_n),
        .lamp(lamp), .score(score), .miss(miss), .ingame(ingame),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Waits for a lamp to light; each new hole must be one-hot and differ from the last.
    task automatic wait_lit(output int cnt);
        cnt = 0;
        while (lamp == 4'h0 && cnt < 100) begin
            tick(1);
            cnt++;
        end
        check("lit_onehot", $countones(lamp), 1);
        check("lit_new_hole", 32'(lamp != last_lamp), 1);
        last_lamp = lamp;
    endtask

    task automatic lit_len(input logic [3:0] hh, output int cnt);
        cnt = 0;
        while (lamp == hh && cnt < 100) begin
            tick(1);
            cnt++;
        end
    endtask

    task automatic hit_once();
        int c;
        wait_lit(c);
        btn_n = ~lamp;
        tick(3);
        btn_n = 4'hF;
    endtask

    task automatic pick_others(input logic [3:0] lit);
        other = ~lit;
        w1 = other & (~other + 4'd1);
        w2 = other & ~w1;
        w2 = w2 & (~w2 + 4'd1);
    endtask

    // Start, hit, timeout, wrong whack, game over; must follow a 2-edge reset.
    task automatic run_a(input bit replay);
        logic [3:0] hh [0:2];
        int c;
        start_n = 1'b0;
        tick(2);
        check("ingame_before_start", ingame, 0);
        tick(1);
        check("ingame_after_start", ingame, 1);
        check("lamp_gap", lamp, 0);
        start_n = 1'b1;
        wait_lit(c);
        check("first_gap_len", c, 5);
        hh[0] = lamp;

        btn_n = ~lamp;
        tick(2);
        check("score_before_hit", score, 0);
        check("hit_pulse_early", hit_pulse, 0);
        tick(1);
        check("score_hit", score, 1);
        check("hit_pulse", hit_pulse, 1);
        check("lamp_clear_on_hit", lamp, 0);
        btn_n = 4'hF;
        tick(1);
        check("hit_pulse_one_cycle", hit_pulse, 0);
        wait_lit(c);
        check("gap_after_hit", c, 4);
        hh[1] = lamp;

        lit_len(hh[1], c);
        check("timeout_window", c, 20);
        check("miss_timeout", miss, 1);
        check("miss_pulse", miss_pulse, 1);
        tick(1);
        check("miss_pulse_one_cycle", miss_pulse, 0);
        wait_lit(c);
        hh[2] = lamp;

        pick_others(lamp);
        btn_n = ~w1;
        tick(3);
        check("miss_wrong", miss, 2);
        check("lamp_stays_on_wrong", lamp, hh[2]);
        btn_n = 4'hF;
        lit_len(hh[2], c);
        check("timer_after_wrong", c, 17);
        check("over_lamp", lamp, 4'hF);
        check("over_ingame", ingame, 0);
        check("over_score", score, 1);
        check("over_miss", miss, 3);

        for (int i = 0; i < 3; i++) begin
            if (replay) check("replay_hole", hh[i], rec[i]);
            else rec[i] = hh[i];
        end
    endtask

    initial begin
        reset = 1'b1;
        start_n = 1'b1;
        btn_n = 4'hF;
        last_lamp = 4'h1;
        tick(2);
        check("rst_lamp", lamp, 0);
        check("rst_score", score, 0);
        check("rst_miss", miss, 0);
        check("rst_ingame", ingame, 0);
        check("rst_hit_pulse", hit_pulse, 0);
        check("rst_miss_pulse", miss_pulse, 0);
        reset = 1'b0;
        run_a(1'b0);

        // Restart from OVER, then simultaneous events.
        start_n = 1'b0;
        tick(3);
        start_n = 1'b1;
        check("restart_score", score, 0);
        check("restart_miss", miss, 0);
        check("restart_ingame", ingame, 1);

        wait_lit(n);
        pick_others(lamp);
        btn_n = ~(lamp | w1);
        tick(3);
        btn_n = 4'hF;
        check("both_score", score, 1);
        check("both_miss", miss, 0);
        check("both_hit_pulse", hit_pulse, 1);
        check("both_miss_pulse", miss_pulse, 0);

        wait_lit(n);
        h = lamp;
        tick(17);
        btn_n = ~h;
        tick(2);
        check("lit_before_last", lamp, h);
        tick(1);
        btn_n = 4'hF;
        check("edge_hit_score", score, 2);
        check("edge_hit_miss", miss, 0);
        check("edge_hit_lamp", lamp, 0);

        wait_lit(n);
        h = lamp;
        pick_others(lamp);
        btn_n = ~(w1 | w2);
        tick(3);
        check("two_wrong_miss", miss, 1);
        check("two_wrong_lamp", lamp, h);
        tick(1);
        btn_n = 4'hF;
        check("two_wrong_once", miss, 1);

        // Mid-game reset, then identical stimulus must reproduce the hole sequence.
        reset = 1'b1;
        tick(1);
        check("midrst_lamp", lamp, 0);
        check("midrst_ingame", ingame, 0);
        check("midrst_score", score, 0);
        tick(1);
        reset = 1'b0;
        last_lamp = 4'h1;
        run_a(1'b1);

        // Speed-up: windows after 8, 16, 24 hits.
        start_n = 1'b0;
        tick(3);
        start_n = 1'b1;
        for (int i = 0; i < 8; i++) hit_once();
        check("score_8", score, 8);
        wait_lit(n);
        lit_len(lamp, n);
        check("window_8", n, 16);
        for (int i = 0; i < 8; i++) hit_once();
        check("score_16", score, 16);
        wait_lit(n);
        lit_len(lamp, n);
        check("window_16", n, 12);
        for (int i = 0; i < 8; i++) hit_once();
        check("score_24", score, 24);
        wait_lit(n);
        lit_len(lamp, n);
        check("window_24", n, 8);
        check("window_24_over", lamp, 4'hF);

        start_n = 1'b0;
        tick(3);
        start_n = 1'b1;
        check("restart2_miss", miss, 0);
        for (int i = 0; i < 32; i++) hit_once();
        check("score_32", score, 32);
        wait_lit(n);
        lit_len(lamp, n);
        check("window_32", n, 8);
        check("miss_after_32", miss, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mole_round_scheduler.md
Name: mole_round_scheduler

Overview:
- Game sequencer for the whack-a-mole board: four lamp outputs, four active-low push buttons and one active-low start button.
- Runs the IDLE/GAP/UP/OVER game state machine and picks the next lit hole with an LFSR.
- Times each lamp window, judges hits, wrong whacks and timeouts, and keeps the score and miss counts.
- The score feeds the LED and VGA score display; `ingame` gates the display's game screen.

Parameters:
- NUM_HOLES, 4, number of lamp/button pairs; power of 2, range 2..8.
- GAP_CYCLES, 50000000, cycles all lamps stay dark between rounds.
- UP_CYCLES, 250000000, initial lit window per round, in cycles.
- UP_STEP, 25000000, amount the lit window shrinks after every 8th hit.
- UP_MIN, 50000000, floor for the lit window.
- MAX_MISS, 10, miss count that ends the game.
- LFSR_SEED, 16'hACE1, LFSR value after reset; must be nonzero.

Ports:
- clk, input, 1, system clock (100 MHz).
- reset, input, 1, synchronous, active-high.
- start_n, input, 1, start button, active-low, asynchronous to clk.
- btn_n, input, NUM_HOLES, hole buttons, active-low, asynchronous to clk.
- lamp, output, NUM_HOLES, lamp drive; 1 = lit.
- score, output, 32, hits this game.
- miss, output, 32, misses this game.
- ingame, output, 1, high in GAP and UP.
- hit_pulse, output, 1, one-cycle pulse on each scored hit.
- miss_pulse, output, 1, one-cycle pulse on each counted miss.

Behaviour:
- **Reset** (one clk edge with reset=1):
  - state=IDLE; lamp=0, score=0, miss=0, ingame=0, hit_pulse=0, miss_pulse=0.
  - lfsr=LFSR_SEED; up_len=UP_CYCLES; timer=0; prev_hole=0.
  - Synchroniser and edge flops = 1 (released).
  - Reset asserted mid-game has the same effect on the next edge.
- **Input conditioning**, per button including start:
  - 2-flop synchroniser, then a history flop.
  - press = history & ~sync2, i.e. a falling edge.
  - A press acts on the 3rd rising edge after btn_n falls. No debounce: a bounce produces extra presses.
- **LFSR**: 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle when not in reset.
- **Hole selection**, on the GAP->UP transition:
  - cand = lfsr[log2(NUM_HOLES)-1:0].
  - hole = cand, or (cand+1) mod NUM_HOLES if cand == prev_hole.
  - prev_hole <= hole.
- **IDLE**: lamp=0, ingame=0. Start press -> GAP with score=0, miss=0, up_len=UP_CYCLES, timer=0.
- **GAP**:
  - lamp=0, ingame=1.
  - Hole presses are ignored.
  - timer counts up; when timer == GAP_CYCLES-1 -> UP with timer=0.
- **UP**: lamp = one-hot(hole), ingame=1. In each cycle the first matching rule applies:
  1. Press on hole: score+1, hit_pulse=1, -> GAP, timer=0. Also, if the new score[2:0]==0, up_len = max(up_len-UP_STEP, UP_MIN). A hit beats a timeout in the same cycle and beats simultaneous wrong presses.
  2. timer == up_len-1: miss+1, miss_pulse=1, -> GAP, timer=0.
  3. Any press on another hole: miss+1, miss_pulse=1, stay in UP, timer continues. Several wrong presses in the same cycle count as one miss.
- **Game end**: in the same cycle as the update that makes the new miss value reach MAX_MISS, state -> OVER instead of GAP/UP.
- **OVER**:
  - lamp = all 1, ingame=0.
  - score and miss hold their final values for display.
  - Start press -> GAP with counters cleared as from IDLE.
- **Start button** is ignored in GAP and UP.
- **Output timing and width**:
  - lamp and ingame are registered, valid the cycle after each state change.
  - score wraps modulo 2^32; miss cannot exceed MAX_MISS.
  - timer and up_len are 32-bit unsigned.

Test Plan (bench params: NUM_HOLES=4, GAP_CYCLES=5, UP_CYCLES=20, UP_STEP=4, UP_MIN=8, MAX_MISS=3):
- **Reset and start**: assert reset 2 cycles -> all outputs 0. Pulse start_n low -> ingame=1 on the edge after the press registers; lamp=0 for 5 cycles, then exactly one lamp bit set.
- **Hit**: press the lit button within the window -> score 0->1 and hit_pulse one cycle, 3 edges after the fall; lamp clears; next lamp lights 5 cycles later on a different hole than before.
- **Timeout and wrong whack**: never press -> miss increments after 20 lit cycles. Then press an unlit button -> miss+1, the lit lamp stays on and its timer is unaffected. The 3rd miss -> lamp=4'b1111, ingame=0, score held.
- **Simultaneous events**:
  - Correct and wrong buttons falling on the same edge -> score+1, miss unchanged.
  - Press registering on the cycle timer==up_len-1 -> counted as a hit.
  - Two wrong buttons in the same cycle -> miss+1 only.
- **Speed-up**: 8 hits -> the lit window measures 16 cycles; after 16 and 24 hits it measures 12 and 8; after 32 hits it stays at 8.
- **Restart and mid-game reset**:
  - Start from OVER -> score=0, miss=0, ingame=1.
  - Reset asserted in UP -> IDLE and lamp=0 on the next edge.
  - Reset followed by the identical start/press stimulus -> the same hole sequence as the first run.
